fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Shares one FPU instance between two independent requesters (port 0, port 1).
- Handles request/acknowledge on the requester side and one start pulse per operation on the FPU side.
- Waits for FPU completion, guarded by a watchdog, then returns result and status to the granting requester.
- Sits between the issuing units and the FPU. Arbitration is round-robin, so neither requester can starve the other.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before aborting the operation (minimum 2).
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  request; held high until the matching ack
- a0, b0, a1, b1  in  32  operands: [31] sign, [30:24] exponent, [23:0] mantissa
- op0, op1  in  2  operation: 00 add, 01 sub, 10/11 reserved
- ack0, ack1  out  1  one-cycle pulse: request accepted, operands latched
- resp_valid0, resp_valid1  out  1  one-cycle pulse: resp_data/resp_status/resp_err valid for that port
- resp_data  out  32  result (shared bus, qualified by resp_valid*)
- resp_status  out  4  FPU status passthrough: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT
- resp_err  out  1  1 = reserved op or watchdog timeout; data and status forced to 0
- busy  out  1  high in every state except IDLE
- fpu_a, fpu_b  out  32  registered operands to the FPU
- fpu_op  out  2  registered op to the FPU
- fpu_start  out  1  one-cycle start pulse
- fpu_done  in  1  FPU completion pulse
- fpu_data  in  32  FPU result, valid with fpu_done
- fpu_status  in  4  FPU status, valid with fpu_done
- timeout_cnt  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; every output = 0; watchdog = 0; timeout_cnt = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Reset while busy: the operation is abandoned and no resp_valid is produced. The FPU shares the same reset.
- State machine, all outputs registered:
  - IDLE:
    - If neither req is high: stay.
    - If exactly one req is high: grant that port.
    - If both are high: grant the port != last_grant.
    - On grant: latch a/b/op into fpu_a/fpu_b/fpu_op, record gid, pulse ack<gid> on the next cycle.
    - Granted op in {10, 11}: go to RESP with resp_err = 1, data 0, status 0; the FPU is not started.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): fpu_start = 1, ack<gid> = 1, watchdog cleared, go to WAIT. fpu_done in this cycle is ignored.
  - WAIT:
    - fpu_done = 1: capture fpu_data/fpu_status into resp_data/resp_status, resp_err = 0, go to RESP.
    - Else, watchdog == TIMEOUT_CYCLES-1: resp_err = 1, resp_data = 0, resp_status = 0, timeout_cnt++ (saturating at 255), go to RESP.
    - Else: watchdog++.
    - fpu_done and watchdog expiry in the same cycle: fpu_done wins.
  - RESP (1 cycle): resp_valid<gid> = 1, last_grant = gid, go to IDLE.
    - resp_data/resp_status/resp_err hold their values until the next capture.
    - For reserved ops, ack<gid> also pulses in this cycle.
- fpu_a/fpu_b/fpu_op hold stable from ISSUE through RESP.
- fpu_start is exactly one cycle per accepted legal op. A second start is never issued before done or timeout.
- Latency:
  - req to ack: 2 cycles.
  - Response arrives 2 cycles after fpu_done (fpu_done in WAIT cycle N → capture at edge N → RESP in cycle N+1 → resp_valid registered, visible at N+2).
  - Minimum req to resp_valid: 5 cycles with a 1-cycle FPU.
- Invariants:
  - At most one ack and at most one resp_valid are high in any cycle.
  - Requests arriving while busy wait; they are never dropped.
  - A requester that deasserts req before its ack is not served, provided it deasserts before the IDLE sampling cycle.

Test Plan:
- Single add: req0 with a0 = 0x3F000000 (1.0), b0 = 0x3F000000, op0 = 00; FPU model returns 0x40000000, status 0001 → one fpu_start, ack0, resp_valid0 with resp_data = 0x40000000, resp_status = 0001, resp_err = 0.
- Tie and round-robin: req0 and req1 held continuously for 4 operations → grants alternate 0,1,0,1 starting with port 0; no fpu_start overlap.
- Reserved op: req1 with op1 = 11 → ack1 and resp_valid1 with resp_err = 1, resp_data = 0; fpu_start never asserted.
- Watchdog: FPU model never asserts fpu_done, TIMEOUT_CYCLES = 8 → resp_err = 1, resp_data = 0, timeout_cnt = 1. The next request is served normally.
- Boundary: fpu_done on the same cycle the watchdog hits TIMEOUT_CYCLES-1 → FPU result returned, resp_err = 0, timeout_cnt unchanged.
- Reset mid-WAIT: assert reset for 1 cycle → all outputs 0, busy = 0, no resp_valid. The first tie afterwards grants port 0.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Purpose: shares one FPU between two requesters using round-robin arbitration and a done-watchdog.
// Latency: req->ack 2 cycles, fpu_done->resp_valid 2 cycles, 5 cycles minimum req->resp_valid.
// Backpressure: one operation in flight; other requests stay pending (req held) until IDLE grants them.
module fpu_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic        resp_valid0,
  output logic        resp_valid1,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_status,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             gid_q, gid_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [3:0]       resp_status_q, resp_status_d;
  logic             resp_err_q, resp_err_d;
  logic             busy_q, busy_d;
  logic [31:0]      fpu_a_q, fpu_a_d;
  logic [31:0]      fpu_b_q, fpu_b_d;
  logic [1:0]       fpu_op_q, fpu_op_d;
  logic             fpu_start_q, fpu_start_d;
  logic [7:0]       timeout_cnt_q, timeout_cnt_d;

  // A reserved op acks in the same cycle the arbiter is back in IDLE, while
  // that requester may still be holding req. Masking a port whose ack is
  // currently visible keeps that already-served request from being granted twice.
  logic       r0_eff, r1_eff;
  logic       gsel;
  logic [1:0] grant_op;

  assign r0_eff   = req0 & ~ack0_q;
  assign r1_eff   = req1 & ~ack1_q;
  // Tie goes to the port that did not finish last; otherwise the lone requester.
  assign gsel     = (r0_eff & r1_eff) ? ~last_grant_q : r1_eff;
  assign grant_op = gsel ? op1 : op0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d       = state_q;
    gid_d         = gid_q;
    last_grant_d  = last_grant_q;
    wd_d          = wd_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rv0_d         = 1'b0;
    rv1_d         = 1'b0;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    resp_err_d    = resp_err_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    fpu_op_d      = fpu_op_q;
    fpu_start_d   = 1'b0;
    timeout_cnt_d = timeout_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (r0_eff | r1_eff) begin
          gid_d    = gsel;
          fpu_a_d  = gsel ? a1 : a0;
          fpu_b_d  = gsel ? b1 : b0;
          fpu_op_d = grant_op;
          if (grant_op[1]) begin
            // Reserved op: answer with an error, never start the FPU.
            resp_err_d    = 1'b1;
            resp_data_d   = 32'd0;
            resp_status_d = 4'd0;
            state_d       = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        fpu_start_d = 1'b1;
        ack0_d      = ~gid_q;
        ack1_d      = gid_q;
        wd_d        = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        if (fpu_done) begin
          // Completion beats a watchdog expiry landing in the same cycle.
          resp_data_d   = fpu_data;
          resp_status_d = fpu_status;
          resp_err_d    = 1'b0;
          state_d       = RESP;
        end else if (wd_q == WD_LAST) begin
          resp_data_d   = 32'd0;
          resp_status_d = 4'd0;
          resp_err_d    = 1'b1;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
          state_d = RESP;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end

      RESP: begin
        rv0_d        = ~gid_q;
        rv1_d        = gid_q;
        // Reserved ops skipped ISSUE, so their ack goes out with the response.
        if (fpu_op_q[1]) begin
          ack0_d = ~gid_q;
          ack1_d = gid_q;
        end
        last_grant_d = gid_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers; all cleared on reset except last_grant,
  // which starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      gid_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      wd_q          <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rv0_q         <= 1'b0;
      rv1_q         <= 1'b0;
      resp_data_q   <= 32'd0;
      resp_status_q <= 4'd0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      fpu_a_q       <= 32'd0;
      fpu_b_q       <= 32'd0;
      fpu_op_q      <= 2'd0;
      fpu_start_q   <= 1'b0;
      timeout_cnt_q <= 8'd0;
    end else begin
      gid_q         <= gid_d;
      last_grant_q  <= last_grant_d;
      wd_q          <= wd_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rv0_q         <= rv0_d;
      rv1_q         <= rv1_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      fpu_op_q      <= fpu_op_d;
      fpu_start_q   <= fpu_start_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign resp_valid0 = rv0_q;
  assign resp_valid1 = rv1_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign fpu_op      = fpu_op_q;
  assign fpu_start   = fpu_start_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small FPU responder model of configurable latency.
// All outputs are sampled on the falling edge; inputs are driven right after sampling.
// Requesters drop req on seeing their ack unless told to hold it.
module tb_fpu_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  op0, op1;
  logic        ack0, ack1, resp_valid0, resp_valid1;
  logic [31:0] resp_data;
  logic [3:0]  resp_status;
  logic        resp_err, busy;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start, fpu_done;
  logic [31:0] fpu_data;
  logic [3:0]  fpu_status;
  logic [7:0]  timeout_cnt;

  always #5 clk = ~clk;

  fpu_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .ack0(ack0), .ack1(ack1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_data(resp_data), .resp_status(resp_status), .resp_err(resp_err),
    .busy(busy),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_done(fpu_done), .fpu_data(fpu_data), .fpu_status(fpu_status),
    .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    int          port;
    int          c;
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
  } ev_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int starts, overlap, both_ack, both_rv, start_cyc, cd, fpu_lat, t0;
  bit pending, mdl_echo, hold0, hold1;
  logic [31:0] mdl_data;
  logic [3:0]  mdl_status;
  ev_t ackq[$];
  ev_t rvq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t rv_at(input int i);
    ev_t r;
    r = '{port: -1, c: -1, d: 'x, s: 'x, e: 1'bx};
    if (i < rvq.size()) r = rvq[i];
    return r;
  endfunction

  function automatic ev_t ack_at(input int i);
    ev_t r;
    r = '{port: -1, c: -1, d: 'x, s: 'x, e: 1'bx};
    if (i < ackq.size()) r = ackq[i];
    return r;
  endfunction

  // One clock cycle: observe outputs, react as requesters, drive the FPU model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (fpu_start) begin
      starts++;
      if (pending) overlap++;
      pending   = 1'b1;
      cd        = fpu_lat;
      start_cyc = cyc;
    end
    if (ack0 && ack1) both_ack++;
    if (resp_valid0 && resp_valid1) both_rv++;
    if (ack0) begin
      ackq.push_back('{port: 0, c: cyc, d: 32'd0, s: 4'd0, e: 1'b0});
      if (!hold0) req0 = 1'b0;
    end
    if (ack1) begin
      ackq.push_back('{port: 1, c: cyc, d: 32'd0, s: 4'd0, e: 1'b0});
      if (!hold1) req1 = 1'b0;
    end
    if (resp_valid0 || resp_valid1)
      rvq.push_back('{port: (resp_valid1 ? 1 : 0), c: cyc, d: resp_data, s: resp_status, e: resp_err});
    fpu_done = 1'b0;
    if (reset) begin
      pending = 1'b0;
    end else if (pending && fpu_lat >= 0) begin
      if (cd == 0) begin
        fpu_done   = 1'b1;
        fpu_data   = mdl_echo ? fpu_a : mdl_data;
        fpu_status = mdl_status;
        pending    = 1'b0;
      end else begin
        cd--;
      end
    end
  endtask

  task automatic clear_logs();
    ackq.delete();
    rvq.delete();
    starts = 0; overlap = 0; both_ack = 0; both_rv = 0; start_cyc = -1; pending = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (rvq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(rvq.size() >= n), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0; op0 = 2'd0; op1 = 2'd0;
    fpu_done = 1'b0; fpu_data = 32'd0; fpu_status = 4'd0;
    fpu_lat = 1; mdl_echo = 1'b0; mdl_data = 32'd0; mdl_status = 4'd0;
    hold0 = 1'b0; hold1 = 1'b0; cd = 0;
    clear_logs();

    // Reset state
    step(); step();
    chk("reset_ctl", {25'd0, ack0, ack1, resp_valid0, resp_valid1, busy, fpu_start, resp_err}, 32'd0);
    chk("reset_data", resp_data, 32'd0);
    chk("reset_tcnt", 32'(timeout_cnt), 32'd0);
    chk("reset_fpu_a", fpu_a, 32'd0);
    reset = 1'b0;
    step();

    // Tie and round-robin: both held for four operations
    clear_logs();
    a0 = 32'h0000_0AAA; b0 = 32'd1; op0 = 2'b00;
    a1 = 32'h0000_0BBB; b1 = 32'd2; op1 = 2'b00;
    mdl_echo = 1'b1; fpu_lat = 1; mdl_status = 4'b0001;
    hold0 = 1'b1; hold1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    run_until(4, 200, "rr_done");
    req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_ack_port%0d", i), 32'(ack_at(i).port), 32'(i % 2));
      chk($sformatf("rr_rv_port%0d", i), 32'(rv_at(i).port), 32'(i % 2));
      chk($sformatf("rr_rv_data%0d", i), rv_at(i).d, (i % 2) ? 32'h0000_0BBB : 32'h0000_0AAA);
    end
    chk("rr_starts", 32'(starts), 32'd4);
    chk("rr_overlap", 32'(overlap), 32'd0);
    chk("rr_one_ack", 32'(both_ack), 32'd0);
    chk("rr_one_rv", 32'(both_rv), 32'd0);
    step(); step();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Single add on port 0
    clear_logs();
    a0 = 32'h3F00_0000; b0 = 32'h3F00_0000; op0 = 2'b00;
    mdl_echo = 1'b0; mdl_data = 32'h4000_0000; mdl_status = 4'b0001; fpu_lat = 1;
    t0 = cyc; req0 = 1'b1;
    run_until(1, 50, "add_done");
    chk("add_port", 32'(rv_at(0).port), 32'd0);
    chk("add_data", rv_at(0).d, 32'h4000_0000);
    chk("add_status", 32'(rv_at(0).s), 32'd1);
    chk("add_err", 32'(rv_at(0).e), 32'd0);
    chk("add_starts", 32'(starts), 32'd1);
    chk("add_ack_lat", 32'(ack_at(0).c - t0), 32'd2);
    chk("add_rv_lat", 32'(rv_at(0).c - t0), 32'd5);

    // Reserved op on port 1
    step(); clear_logs();
    a1 = 32'h1234_5678; op1 = 2'b11;
    t0 = cyc; req1 = 1'b1;
    run_until(1, 50, "rsv_done");
    repeat (4) step();
    chk("rsv_port", 32'(rv_at(0).port), 32'd1);
    chk("rsv_err", 32'(rv_at(0).e), 32'd1);
    chk("rsv_data", rv_at(0).d, 32'd0);
    chk("rsv_status", 32'(rv_at(0).s), 32'd0);
    chk("rsv_starts", 32'(starts), 32'd0);
    chk("rsv_ack_port", 32'(ack_at(0).port), 32'd1);
    chk("rsv_ack_with_rv", 32'(ack_at(0).c), 32'(rv_at(0).c));
    chk("rsv_rv_lat", 32'(rv_at(0).c - t0), 32'd2);
    chk("rsv_single_rv", 32'(rvq.size()), 32'd1);
    op1 = 2'b00;

    // Watchdog: FPU never answers
    clear_logs();
    a0 = 32'h0101_0101; op0 = 2'b00; fpu_lat = -1;
    req0 = 1'b1;
    run_until(1, 100, "wd_done");
    chk("wd_err", 32'(rv_at(0).e), 32'd1);
    chk("wd_data", rv_at(0).d, 32'd0);
    chk("wd_status", 32'(rv_at(0).s), 32'd0);
    chk("wd_tcnt", 32'(timeout_cnt), 32'd1);
    chk("wd_rv_after_start", 32'(rv_at(0).c - start_cyc), 32'(TO + 1));

    // Next request after a timeout is served normally
    step(); clear_logs();
    fpu_lat = 1; mdl_data = 32'h1111_1111; mdl_status = 4'b1000;
    req1 = 1'b1;
    run_until(1, 50, "wdn_done");
    chk("wdn_port", 32'(rv_at(0).port), 32'd1);
    chk("wdn_data", rv_at(0).d, 32'h1111_1111);
    chk("wdn_status", 32'(rv_at(0).s), 32'h8);
    chk("wdn_err", 32'(rv_at(0).e), 32'd0);
    chk("wdn_tcnt", 32'(timeout_cnt), 32'd1);

    // Boundary: done lands on the last watchdog cycle
    step(); clear_logs();
    fpu_lat = TO - 1; mdl_data = 32'hCAFE_F00D; mdl_status = 4'b0100;
    req0 = 1'b1;
    run_until(1, 100, "bnd_done");
    chk("bnd_data", rv_at(0).d, 32'hCAFE_F00D);
    chk("bnd_status", 32'(rv_at(0).s), 32'h4);
    chk("bnd_err", 32'(rv_at(0).e), 32'd0);
    chk("bnd_tcnt", 32'(timeout_cnt), 32'd1);
    chk("bnd_rv_after_start", 32'(rv_at(0).c - start_cyc), 32'(TO + 1));

    // Reset in the middle of WAIT
    step(); clear_logs();
    fpu_lat = -1; a0 = 32'h0F0F_0F0F; req0 = 1'b1;
    begin
      int k = 0;
      while (starts == 0 && k < 50) begin
        step();
        k++;
      end
    end
    chk("mid_started", 32'(starts), 32'd1);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_ctl", {25'd0, ack0, ack1, resp_valid0, resp_valid1, busy, fpu_start, resp_err}, 32'd0);
    chk("mid_data", resp_data, 32'd0);
    chk("mid_status", 32'(resp_status), 32'd0);
    chk("mid_fpu_a", fpu_a, 32'd0);
    chk("mid_tcnt", 32'(timeout_cnt), 32'd0);
    repeat (12) step();
    chk("mid_no_rv", 32'(rvq.size()), 32'd0);

    // First tie after reset goes to port 0
    clear_logs();
    fpu_lat = 1; mdl_echo = 1'b1;
    a0 = 32'h0000_0AAA; a1 = 32'h0000_0BBB;
    req0 = 1'b1; req1 = 1'b1;
    run_until(2, 100, "post_done");
    chk("post_ack0", 32'(ack_at(0).port), 32'd0);
    chk("post_ack1", 32'(ack_at(1).port), 32'd1);
    chk("post_data0", rv_at(0).d, 32'h0000_0AAA);
    chk("post_data1", rv_at(1).d, 32'h0000_0BBB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
